// File: rtl/instr_stream_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_stream_encoder_if
//
// Purpose:
//   Bundles the instruction-field stream (valid/ready handshake) and the
//   instruction-memory write port used by instr_stream_encoder.
//
// Signals:
//   in_valid    loader -> encoder  instruction fields valid
//   in_ready    encoder -> loader  encoder can accept this cycle
//   in_kind     loader -> encoder  0 LW, 1 SW, 2 R, 3 BEQ, 4 J; 5-7 illegal
//   in_rs       loader -> encoder  source register
//   in_rt       loader -> encoder  target register
//   in_rd       loader -> encoder  destination register (R only)
//   in_imm      loader -> encoder  immediate / funct / jump field
//   in_last     loader -> encoder  final instruction of the program
//   imem_we     encoder -> IMEM    one-cycle write strobe
//   imem_addr   encoder -> IMEM    word address
//   imem_wdata  encoder -> IMEM    encoded instruction word
//
// Modports:
//   master  the loader side (drives the stream, observes the IMEM port)
//   slave   the encoder side
// ---------------------------------------------------------------------------
interface instr_stream_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              in_last;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid,
        output in_kind,
        output in_rs,
        output in_rt,
        output in_rd,
        output in_imm,
        output in_last,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_kind,
        input  in_rs,
        input  in_rt,
        input  in_rd,
        input  in_imm,
        input  in_last,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// ---------------------------------------------------------------------------
// instr_stream_encoder
//
// Purpose:
//   Program-side producer of instruction words for the opcode decoder. The
//   boot/test loader streams instruction fields in; each legal beat is packed
//   into a 32-bit word (opcode = kind in bits [31:26]) and written to
//   instruction memory at consecutive word addresses starting from 0.
//
// Parameters:
//   IMEM_DEPTH  number of words a session may write (session ends there)
//   ADDR_W      IMEM word-address width, 2**ADDR_W >= IMEM_DEPTH
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       begin / restart a load session (clears address, count, errors)
//   bus         stream + IMEM write port (slave modport)
//   busy        session in progress (RUN)
//   done        session finished (DONE), level
//   err_kind    sticky: an illegal kind was consumed this session
//   err_full    sticky: IMEM_DEPTH words written without in_last
//   count       words written this session
//
// Timing:
//   A beat accepted at edge N produces imem_we=1 with registered address and
//   data during the following cycle; count steps at that same edge.
// ---------------------------------------------------------------------------
module instr_stream_encoder #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    instr_stream_encoder_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_kind,
    output logic                  err_full,
    output logic [ADDR_W:0]       count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] KIND_LW  = 3'd0;
    localparam logic [2:0] KIND_SW  = 3'd1;
    localparam logic [2:0] KIND_R   = 3'd2;
    localparam logic [2:0] KIND_BEQ = 3'd3;
    localparam logic [2:0] KIND_J   = 3'd4;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] LAST_SLOT = DEPTH_CNT - (ADDR_W+1)'(1);

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic        room;
    logic        accept;
    logic        kind_legal;
    logic        at_last_slot;
    logic        fill_word;
    logic [31:0] word;

    // count only ever holds legal words, so it doubles as the next write
    // address and as the "accepted words" figure that gates in_ready.
    assign room         = (count < DEPTH_CNT);
    assign bus.in_ready = (state == ST_RUN) && !start && room;
    assign accept       = bus.in_valid && bus.in_ready;
    assign kind_legal   = (bus.in_kind <= KIND_J);
    assign at_last_slot = (count == LAST_SLOT);
    assign fill_word    = accept && kind_legal && at_last_slot;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Field packing; high immediate bits beyond each format are dropped.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        word = '0;
        case (bus.in_kind)
            KIND_LW, KIND_SW, KIND_BEQ:
                word = {3'b000, bus.in_kind, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            KIND_R:
                word = {3'b000, bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm[10:0]};
            KIND_J:
                word = {3'b000, bus.in_kind, bus.in_imm};
            default:
                word = '0;
        endcase
    end

    // Session control. start wins over any beat (in_ready is low while it is
    // high), so accept already implies !start in RUN.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (accept && (bus.in_last || fill_word)) state_nx = ST_DONE;
            ST_DONE: if (start) state_nx = ST_RUN;
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            count          <= '0;
            err_kind       <= 1'b0;
            err_full       <= 1'b0;
        end else begin
            state       <= state_nx;
            // One strobe per legal beat; illegal kinds are consumed silently.
            bus.imem_we <= accept && kind_legal;

            if (start) begin
                count         <= '0;
                err_kind      <= 1'b0;
                err_full      <= 1'b0;
                bus.imem_addr <= '0;
            end else if (accept) begin
                if (kind_legal) begin
                    bus.imem_addr  <= count[ADDR_W-1:0];
                    bus.imem_wdata <= word;
                    count          <= count + (ADDR_W+1)'(1);
                    // Filling the last slot is only an error if the program
                    // did not end exactly there.
                    if (at_last_slot && !bus.in_last) err_full <= 1'b1;
                end else begin
                    err_kind <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_stream_encoder
//
// Bench for instr_stream_encoder built with IMEM_DEPTH=4 and ADDR_W=3 so the
// session-full rule is reached well before the address range runs out.
// Encoding vectors come from a table of hand-computed words; program-level
// expectations come from a transaction model that walks the beat list and
// builds the list of (address, word) writes with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_instr_stream_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [25:0] imm;
        logic        last;
    } beat_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        beat_t       b;
        logic [31:0] word;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          err_kind;
    logic          err_full;
    logic [AW:0]   count;

    instr_stream_encoder_if #(.ADDR_W(AW)) bus_if ();

    instr_stream_encoder #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus_if.slave),
        .busy     (busy),
        .done     (done),
        .err_kind (err_kind),
        .err_full (err_full),
        .count    (count)
    );

    always #5 clk = ~clk;

    int    cmp_cnt = 0;
    int    err_cnt = 0;
    wr_t   act_q[$];
    wr_t   exp_q[$];
    beat_t prog[$];
    int unsigned exp_count;
    bit    exp_ek;
    bit    exp_ef;
    bit    exp_done;
    int    n_consume;

    // Write monitor: every strobe observed mid-cycle is one IMEM write.
    always @(negedge clk) begin : monitor
        wr_t w;
        if (bus_if.imem_we === 1'b1) begin
            w.addr = bus_if.imem_addr;
            w.data = bus_if.imem_wdata;
            act_q.push_back(w);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding: opcode times 2^26 plus each field times its weight.
    function automatic logic [31:0] enc(input beat_t b);
        int unsigned k, rs, rt, rd, imm, w;
        k   = b.kind;
        rs  = b.rs;
        rt  = b.rt;
        rd  = b.rd;
        imm = b.imm;
        w   = k * 67108864;
        if (k == 2)
            w = w + rs * 2097152 + rt * 65536 + rd * 2048 + (imm % 2048);
        else if (k == 4)
            w = w + imm;
        else
            w = w + rs * 2097152 + rt * 65536 + (imm % 65536);
        return w;
    endfunction

    // Session model: which beats get consumed, what lands where, final flags.
    function automatic void model_program();
        int unsigned n;
        wr_t         w;
        n = 0;
        exp_q.delete();
        exp_ek    = 0;
        exp_ef    = 0;
        exp_done  = 0;
        n_consume = 0;
        foreach (prog[i]) begin
            if (exp_done) break;
            n_consume++;
            if (prog[i].kind > 3'd4) begin
                exp_ek = 1;
                if (prog[i].last) exp_done = 1;
            end else begin
                w.addr = n;
                w.data = enc(prog[i]);
                exp_q.push_back(w);
                n++;
                if (prog[i].last) exp_done = 1;
                else if (n == DEPTH) begin
                    exp_ef   = 1;
                    exp_done = 1;
                end
            end
        end
        exp_count = n;
    endfunction

    function automatic beat_t mk(input int kind, input int rs, input int rt, input int rd,
                                 input int imm, input bit last);
        beat_t b;
        b.kind = 3'(kind);
        b.rs   = 5'(rs);
        b.rt   = 5'(rt);
        b.rd   = 5'(rd);
        b.imm  = 26'(imm);
        b.last = last;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields(input beat_t b);
        bus_if.in_kind = b.kind;
        bus_if.in_rs   = b.rs;
        bus_if.in_rt   = b.rt;
        bus_if.in_rd   = b.rd;
        bus_if.in_imm  = b.imm;
        bus_if.in_last = b.last;
    endtask

    task automatic do_start();
        bus_if.in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        act_q.delete();
    endtask

    // Presents a beat and holds it until a clock edge sees valid && ready.
    task automatic send_beat(input beat_t b, input int gap);
        logic rdy;
        bit   accepted;
        accepted = 0;
        repeat (gap) tick();
        drive_fields(b);
        bus_if.in_valid = 1'b1;
        for (int t = 0; t < 20 && !accepted; t++) begin
            @(negedge clk);
            rdy = bus_if.in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) accepted = 1;
        end
        bus_if.in_valid = 1'b0;
        if (!accepted) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL accept_timeout: kind %0d not accepted in 20 cycles, expected acceptance", b.kind);
        end
    endtask

    task automatic check_session(input string name);
        tick();
        tick();
        check({name, "_nwrites"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) begin
                check($sformatf("%s_addr%0d", name, i), act_q[i].addr, exp_q[i].addr);
                check($sformatf("%s_data%0d", name, i), act_q[i].data, exp_q[i].data);
            end
        end
        check({name, "_count"},    32'(count),     exp_count);
        check({name, "_done"},     32'(done),      32'(exp_done));
        check({name, "_busy"},     32'(busy),      32'(!exp_done));
        check({name, "_in_ready"}, 32'(bus_if.in_ready), 32'(!exp_done));
        check({name, "_err_kind"}, 32'(err_kind),  32'(exp_ek));
        check({name, "_err_full"}, 32'(err_full),  32'(exp_ef));
    endtask

    task automatic run_prog(input string name);
        model_program();
        do_start();
        for (int i = 0; i < n_consume; i++) send_beat(prog[i], int'($urandom_range(0, 2)));
        check_session(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},     32'(busy),     0);
        check({name, "_done"},     32'(done),     0);
        check({name, "_count"},    32'(count),    0);
        check({name, "_err_kind"}, 32'(err_kind), 0);
        check({name, "_err_full"}, 32'(err_full), 0);
        check({name, "_we"},       32'(bus_if.imem_we),   0);
        check({name, "_addr"},     32'(bus_if.imem_addr), 0);
        check({name, "_wdata"},    bus_if.imem_wdata,     0);
        check({name, "_in_ready"}, 32'(bus_if.in_ready),  0);
    endtask

    initial begin
        vec_t  vecs[8];
        beat_t b;
        beat_t x;
        int    len;

        vecs[0] = '{mk(0, 1, 2, 0, 'h0004, 1),       32'h00220004};
        vecs[1] = '{mk(2, 3, 4, 5, 'h020, 1),        32'h08642820};
        vecs[2] = '{mk(3, 1, 1, 0, 'hFFFF, 1),       32'h0C21FFFF};
        vecs[3] = '{mk(4, 0, 0, 0, 'h3FFFFFF, 1),    32'h13FFFFFF};
        vecs[4] = '{mk(1, 31, 31, 0, 0, 1),          32'h07FF0000};
        vecs[5] = '{mk(0, 0, 0, 7, 'h3FF1234, 1),    32'h00001234};
        vecs[6] = '{mk(2, 0, 0, 0, 'h3FFFFFF, 1),    32'h080007FF};
        vecs[7] = '{mk(2, 31, 0, 31, 0, 1),          32'h0BE0F800};

        rst             = 1'b1;
        start           = 1'b0;
        bus_if.in_valid = 1'b0;
        drive_fields(mk(0, 0, 0, 0, 0, 0));
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single-word encoding table.
        foreach (vecs[i]) begin
            do_start();
            send_beat(vecs[i].b, 0);
            tick();
            tick();
            check($sformatf("vec%0d_nwrites", i), act_q.size(), 1);
            if (act_q.size() > 0) begin
                check($sformatf("vec%0d_word", i), act_q[0].data, vecs[i].word);
                check($sformatf("vec%0d_addr", i), act_q[0].addr, 0);
            end
            check($sformatf("vec%0d_done", i), 32'(done), 1);
        end

        // LW then R with last.
        prog = '{mk(0, 1, 2, 0, 'h0004, 0), mk(2, 3, 4, 5, 'h020, 1)};
        run_prog("t1");
        if (act_q.size() == 2) begin
            check("t1_word0", act_q[0].data, 32'h00220004);
            check("t1_word1", act_q[1].data, 32'h08642820);
        end

        // BEQ then J with last.
        prog = '{mk(3, 1, 1, 0, 'hFFFF, 0), mk(4, 0, 0, 0, 'h3FFFFFF, 1)};
        run_prog("t2");
        if (act_q.size() == 2) begin
            check("t2_word0", act_q[0].data, 32'h0C21FFFF);
            check("t2_word1", act_q[1].data, 32'h13FFFFFF);
        end

        // Illegal kind between two SW beats.
        prog = '{mk(1, 2, 3, 0, 'h10, 0), mk(6, 9, 9, 9, 'h55, 0), mk(1, 4, 5, 0, 'h20, 1)};
        run_prog("t3");

        // Illegal kind carrying last ends the session without a write.
        prog = '{mk(0, 1, 1, 0, 1, 0), mk(7, 0, 0, 0, 0, 1)};
        run_prog("t3b");

        // Six beats, no last: session fills at four.
        prog = '{};
        for (int i = 0; i < 6; i++) prog.push_back(mk(i % 5, i, i + 1, i + 2, i * 3, 0));
        model_program();
        do_start();
        for (int i = 0; i < n_consume; i++) send_beat(prog[i], 0);
        drive_fields(prog[4]);
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4_ready_low%0d", i), 32'(bus_if.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check_session("t4");

        // Fourth word carries last: done without err_full.
        prog = '{mk(0, 1, 2, 0, 1, 0), mk(1, 1, 2, 0, 2, 0), mk(3, 1, 2, 0, 3, 0), mk(4, 0, 0, 0, 4, 1)};
        run_prog("t4b");

        // Reset the cycle after an accept drops the following beat.
        do_start();
        send_beat(mk(0, 5, 6, 0, 'h77, 0), 0);
        rst = 1'b1;
        drive_fields(mk(1, 7, 7, 0, 'h99, 0));
        bus_if.in_valid = 1'b1;
        tick();
        rst             = 1'b0;
        bus_if.in_valid = 1'b0;
        check("t5_writes_before_rst", act_q.size(), 1);
        tick();
        check("t5_writes_after_rst", act_q.size(), 1);
        check_all_zero("t5_post_rst");
        prog = '{mk(0, 2, 3, 0, 'h44, 1)};
        run_prog("t5_restart");

        // start together with a valid beat mid-session.
        prog = '{mk(0, 1, 1, 0, 1, 0), mk(1, 2, 2, 0, 2, 0), mk(2, 3, 3, 3, 3, 0)};
        do_start();
        for (int i = 0; i < 3; i++) send_beat(prog[i], 0);
        tick();
        check("t6_count_before", 32'(count), 3);
        x = mk(3, 8, 9, 0, 'h1234, 1);
        drive_fields(x);
        bus_if.in_valid = 1'b1;
        start           = 1'b1;
        @(negedge clk);
        check("t6_ready_during_start", 32'(bus_if.in_ready), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        act_q.delete();
        check("t6_count_cleared", 32'(count), 0);
        send_beat(x, 0);
        prog = '{x};
        model_program();
        check_session("t6");

        // Randomised programs against the session model.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            prog = '{};
            len  = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                b.kind = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
                b.rs   = 5'($urandom);
                b.rt   = 5'($urandom);
                b.rd   = 5'($urandom);
                b.imm  = 26'($urandom);
                b.last = (i == len - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                prog.push_back(b);
            end
            run_prog($sformatf("rnd%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
